// File: rtl/axi_rd_arbiter2_if.sv
// rtl/axi_rd_arbiter2_if.sv - AR/R bus bundle for the two-requester read arbiter
interface axi_rd_arbiter2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]        s0_arlen,  s1_arlen,  m_arlen;
  logic [2:0]        s0_arsize, s1_arsize, m_arsize;
  logic [1:0]        s0_arburst, s1_arburst, m_arburst;
  logic              s0_arvalid, s1_arvalid, m_arvalid;
  logic              s0_arready, s1_arready, m_arready;
  logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]        s0_rresp, s1_rresp, m_rresp;
  logic              s0_rlast, s1_rlast, m_rlast;
  logic              s0_rvalid, s1_rvalid, m_rvalid;
  logic              s0_rready, s1_rready, m_rready;

  // arbiter side: serves the two requesters, drives the shared downstream port
  modport slave (
    input  s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid, s0_rready,
    input  s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid, s1_rready,
    output s0_arready, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
    output s1_arready, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport master (
    output s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid, s0_rready,
    output s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid, s1_rready,
    input  s0_arready, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
    input  s1_arready, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter2.sv
// rtl/axi_rd_arbiter2.sv - two-requester AXI read arbiter, one outstanding burst at a time
module axi_rd_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  axi_rd_arbiter2_if.slave bus,
  output logic             grant,
  output logic             busy,
  output logic             protocol_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            r_state, w_next;
  logic              r_grant, r_last_grant, r_err;
  logic [7:0]        r_beat_cnt, r_len;
  logic              w_any_req, w_pick, w_ar_hs, w_r_hs;
  logic [ADDR_W-1:0] w_araddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_any_req    = bus.s0_arvalid | bus.s1_arvalid;
  assign w_rdata      = bus.m_rdata;
  assign grant        = r_grant;
  assign busy         = (r_state != IDLE);
  assign protocol_err = r_err;

  always_comb begin
    if (bus.s0_arvalid && bus.s1_arvalid) w_pick = RR ? ~r_last_grant : 1'b0;
    else                                  w_pick = bus.s1_arvalid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ar_hs        = 1'b0;
    w_r_hs         = 1'b0;
    w_araddr       = '0;
    bus.m_arlen    = '0;
    bus.m_arsize   = '0;
    bus.m_arburst  = '0;
    bus.m_arvalid  = 1'b0;
    bus.m_rready   = 1'b0;
    bus.s0_arready = 1'b0;
    bus.s1_arready = 1'b0;
    bus.s0_rdata   = '0;
    bus.s0_rresp   = '0;
    bus.s0_rlast   = 1'b0;
    bus.s0_rvalid  = 1'b0;
    bus.s1_rdata   = '0;
    bus.s1_rresp   = '0;
    bus.s1_rlast   = 1'b0;
    bus.s1_rvalid  = 1'b0;
    case (r_state)
      IDLE: if (w_any_req) w_next = ADDR;
      ADDR: begin
        // arvalid comes only from the requester, so m_arready never loops back into it
        if (r_grant) begin
          w_araddr      = bus.s1_araddr;
          bus.m_arlen   = bus.s1_arlen;
          bus.m_arsize  = bus.s1_arsize;
          bus.m_arburst = bus.s1_arburst;
          bus.m_arvalid = bus.s1_arvalid;
        end else begin
          w_araddr      = bus.s0_araddr;
          bus.m_arlen   = bus.s0_arlen;
          bus.m_arsize  = bus.s0_arsize;
          bus.m_arburst = bus.s0_arburst;
          bus.m_arvalid = bus.s0_arvalid;
        end
        bus.s0_arready = !r_grant && bus.m_arready;
        bus.s1_arready = r_grant && bus.m_arready;
        w_ar_hs        = bus.m_arvalid && bus.m_arready;
        if (w_ar_hs) w_next = DATA;
      end
      DATA: begin
        if (r_grant) begin
          bus.s1_rdata  = w_rdata;
          bus.s1_rresp  = bus.m_rresp;
          bus.s1_rlast  = bus.m_rlast;
          bus.s1_rvalid = bus.m_rvalid;
          bus.m_rready  = bus.s1_rready;
        end else begin
          bus.s0_rdata  = w_rdata;
          bus.s0_rresp  = bus.m_rresp;
          bus.s0_rlast  = bus.m_rlast;
          bus.s0_rvalid = bus.m_rvalid;
          bus.m_rready  = bus.s0_rready;
        end
        w_r_hs = bus.m_rvalid && bus.m_rready;
        if (w_r_hs && bus.m_rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.m_araddr = w_araddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_len        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any_req) r_grant <= w_pick;
      if (w_ar_hs) begin
        r_len      <= bus.m_arlen;
        r_beat_cnt <= '0;
      end
      if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        // rlast must land exactly on beat arlen; a missing rlast keeps the grant until it shows
        if (bus.m_rlast) begin
          r_last_grant <= r_grant;
          if (r_beat_cnt != r_len) r_err <= 1'b1;
        end else if (r_beat_cnt == r_len) begin
          r_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// tb/tb_axi_rd_arbiter2.sv - scoreboard bench for axi_rd_arbiter2 (round-robin and fixed-priority builds)
module tb_axi_rd_arbiter2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic fp = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  axi_rd_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) b ();
  axi_rd_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) bf ();
  logic g_rr, busy_rr, err_rr, g_fp, busy_fp, err_fp;

  axi_rd_arbiter2 #(.ADDR_W(32), .DATA_W(32), .RR(1'b1)) u_rr (
    .clk(clk), .reset(reset), .bus(b), .grant(g_rr), .busy(busy_rr), .protocol_err(err_rr));
  axi_rd_arbiter2 #(.ADDR_W(32), .DATA_W(32), .RR(1'b0)) u_fp (
    .clk(clk), .reset(reset), .bus(bf), .grant(g_fp), .busy(busy_fp), .protocol_err(err_fp));

  assign bf.s0_araddr = b.s0_araddr;   assign bf.s1_araddr = b.s1_araddr;
  assign bf.s0_arlen = b.s0_arlen;     assign bf.s1_arlen = b.s1_arlen;
  assign bf.s0_arsize = b.s0_arsize;   assign bf.s1_arsize = b.s1_arsize;
  assign bf.s0_arburst = b.s0_arburst; assign bf.s1_arburst = b.s1_arburst;
  assign bf.s0_arvalid = b.s0_arvalid; assign bf.s1_arvalid = b.s1_arvalid;
  assign bf.s0_rready = b.s0_rready;   assign bf.s1_rready = b.s1_rready;
  assign bf.m_arready = b.m_arready;   assign bf.m_rdata = b.m_rdata;
  assign bf.m_rresp = b.m_rresp;       assign bf.m_rlast = b.m_rlast;
  assign bf.m_rvalid = b.m_rvalid;

  wire        d_s0_arready = fp ? bf.s0_arready : b.s0_arready;
  wire        d_s1_arready = fp ? bf.s1_arready : b.s1_arready;
  wire [31:0] d_s0_rdata   = fp ? bf.s0_rdata   : b.s0_rdata;
  wire [31:0] d_s1_rdata   = fp ? bf.s1_rdata   : b.s1_rdata;
  wire [1:0]  d_s0_rresp   = fp ? bf.s0_rresp   : b.s0_rresp;
  wire [1:0]  d_s1_rresp   = fp ? bf.s1_rresp   : b.s1_rresp;
  wire        d_s0_rlast   = fp ? bf.s0_rlast   : b.s0_rlast;
  wire        d_s1_rlast   = fp ? bf.s1_rlast   : b.s1_rlast;
  wire        d_s0_rvalid  = fp ? bf.s0_rvalid  : b.s0_rvalid;
  wire        d_s1_rvalid  = fp ? bf.s1_rvalid  : b.s1_rvalid;
  wire [31:0] d_m_araddr   = fp ? bf.m_araddr   : b.m_araddr;
  wire [7:0]  d_m_arlen    = fp ? bf.m_arlen    : b.m_arlen;
  wire [2:0]  d_m_arsize   = fp ? bf.m_arsize   : b.m_arsize;
  wire [1:0]  d_m_arburst  = fp ? bf.m_arburst  : b.m_arburst;
  wire        d_m_arvalid  = fp ? bf.m_arvalid  : b.m_arvalid;
  wire        d_m_rready   = fp ? bf.m_rready   : b.m_rready;
  wire        d_grant      = fp ? g_fp    : g_rr;
  wire        d_busy       = fp ? busy_fp : busy_rr;
  wire        d_err        = fp ? err_fp  : err_rr;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  logic        obs_grant, arready_ok, to_flag;
  logic [31:0] obs_araddr;
  logic [7:0]  obs_arlen;
  logic [2:0]  obs_arsize;
  logic [1:0]  obs_arburst;
  logic [15:0] busy_tr, err_tr;
  int          ar_wait, mirror_bad;
  int          burst_id = 0;

  task automatic clear_inputs();
    b.s0_araddr = '0; b.s0_arlen = '0; b.s0_arsize = '0; b.s0_arburst = '0; b.s0_arvalid = 0; b.s0_rready = 0;
    b.s1_araddr = '0; b.s1_arlen = '0; b.s1_arsize = '0; b.s1_arburst = '0; b.s1_arvalid = 0; b.s1_rready = 0;
    b.m_arready = 0; b.m_rdata = '0; b.m_rresp = '0; b.m_rlast = 0; b.m_rvalid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Plays the downstream slave for one burst: accepts AR, then returns beats 0..rlast_at.
  task automatic do_burst(input logic sel, input int rlast_at, input bit toggle, input bit keep_req);
    int    i, cyc, pushed;
    bit    hs, r;
    beat_t e, o;
    logic [31:0] dat;
    to_flag = 0; mirror_bad = 0; ar_wait = 0; busy_tr = '0; err_tr = '0;
    @(negedge clk);
    while (d_m_arvalid !== 1'b1 && ar_wait < 20) begin
      ar_wait++;
      @(negedge clk);
    end
    if (ar_wait >= 20) begin
      to_flag = 1;
      return;
    end
    obs_grant = d_grant; obs_araddr = d_m_araddr; obs_arlen = d_m_arlen;
    obs_arsize = d_m_arsize; obs_arburst = d_m_arburst;
    b.m_arready = 1'b1;
    #1;
    arready_ok = sel ? ({d_s1_arready, d_s0_arready} === 2'b10) : ({d_s1_arready, d_s0_arready} === 2'b01);
    @(negedge clk);
    b.m_arready = 1'b0;
    if (!keep_req) begin
      if (sel) b.s1_arvalid = 1'b0; else b.s0_arvalid = 1'b0;
    end
    i = 0; cyc = 0; pushed = -1; hs = 0;
    while (i <= rlast_at && cyc < 200) begin
      if (hs) begin busy_tr[i-1] = d_busy; err_tr[i-1] = d_err; end
      dat = {sel ? 8'hB1 : 8'hA0, 8'(burst_id), 16'(i)};
      b.m_rvalid = 1'b1; b.m_rdata = dat; b.m_rresp = 2'(i); b.m_rlast = (i == rlast_at);
      if (pushed != i) begin
        e.sel = {1'b0, sel}; e.data = dat; e.resp = 2'(i); e.last = (i == rlast_at);
        exp_q.push_back(e);
        pushed = i;
      end
      r = toggle ? ~cyc[0] : 1'b1;
      if (sel) begin b.s1_rready = r; b.s0_rready = ~r; end
      else     begin b.s0_rready = r; b.s1_rready = ~r; end
      #1;
      if (d_m_rready !== r) mirror_bad++;
      hs = (d_m_rready === 1'b1);
      if (hs) begin
        if (d_s0_rvalid && !d_s1_rvalid && {d_s1_rdata, d_s1_rresp, d_s1_rlast} == '0)      o.sel = 2'd0;
        else if (d_s1_rvalid && !d_s0_rvalid && {d_s0_rdata, d_s0_rresp, d_s0_rlast} == '0) o.sel = 2'd1;
        else                                                                                 o.sel = 2'd3;
        o.data = sel ? d_s1_rdata : d_s0_rdata;
        o.resp = sel ? d_s1_rresp : d_s0_rresp;
        o.last = sel ? d_s1_rlast : d_s0_rlast;
        obs_q.push_back(o);
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) to_flag = 1;
    if (hs) begin busy_tr[i-1] = d_busy; err_tr[i-1] = d_err; end
    b.m_rvalid = 0; b.m_rlast = 0; b.s0_rready = 0; b.s1_rready = 0;
    burst_id++;
  endtask

  task automatic test_reset();
    b.s0_arvalid = 1; b.s1_arvalid = 1; b.m_arready = 1; b.m_rvalid = 1; b.s0_rready = 1;
    @(negedge clk);
    #1;
    vectors++;
    if ({d_m_arvalid, d_m_rready, d_s0_arready, d_s1_arready, d_s0_rvalid, d_s1_rvalid, d_grant, d_busy, d_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {d_m_arvalid, d_m_rready, d_s0_arready, d_s1_arready, d_s0_rvalid, d_s1_rvalid, d_grant, d_busy, d_err});
    end
    vectors++;
    if ({d_m_araddr, d_m_arlen} !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_payload: got %h want 0", {d_m_araddr, d_m_arlen});
    end
    clear_inputs();
  endtask

  task automatic test_single();
    beat_t e, o;
    do_reset();
    b.s0_araddr = 32'h100; b.s0_arlen = 8'd3; b.s0_arsize = 3'd2; b.s0_arburst = 2'd1; b.s0_arvalid = 1;
    #1;
    vectors++;
    if (d_m_arvalid !== 1'b0) begin miscompares++; $display("FAIL single_idle_arvalid: got %b want 0", d_m_arvalid); end
    do_burst(1'b0, 3, 1'b0, 1'b0);
    vectors++;
    if (to_flag !== 1'b0 || ar_wait != 0) begin
      miscompares++; $display("FAIL single_latency: timeout %b wait %0d want 0 0", to_flag, ar_wait);
    end
    vectors++;
    if ({obs_grant, arready_ok, obs_araddr, obs_arlen, obs_arsize, obs_arburst} !== {1'b0, 1'b1, 32'h100, 8'd3, 3'd2, 2'd1}) begin
      miscompares++; $display("FAIL single_ar: got %h %b %h %h %h %h want 0 1 100 03 2 1",
                              obs_grant, arready_ok, obs_araddr, obs_arlen, obs_arsize, obs_arburst);
    end
    vectors++;
    if (obs_q.size() != 4) begin miscompares++; $display("FAIL single_count: got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL single_beat: got %h want %h", o, e); end
    end
    vectors++;
    if ({busy_tr[3:0], err_tr[3:0], d_err} !== 9'b0111_0000_0) begin
      miscompares++; $display("FAIL single_busy_err: got %b %b %b want 0111 0000 0", busy_tr[3:0], err_tr[3:0], d_err);
    end
  endtask

  task automatic test_round_robin();
    beat_t e, o;
    logic  s;
    do_reset();
    b.s0_araddr = 32'h200; b.s0_arlen = 8'd1; b.s0_arvalid = 1;
    b.s1_araddr = 32'h300; b.s1_arlen = 8'd1; b.s1_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 1);
      do_burst(s, 1, 1'b0, 1'b1);
      vectors++;
      if ({to_flag, obs_grant, obs_araddr} !== {1'b0, s, s ? 32'h300 : 32'h200} || ar_wait != 0) begin
        miscompares++; $display("FAIL rr_grant%0d: got to=%b g=%b addr=%h wait=%0d want g=%b", k, to_flag, obs_grant, obs_araddr, ar_wait, s);
      end
      vectors++;
      if (busy_tr[1:0] !== 2'b01) begin miscompares++; $display("FAIL rr_gap%0d: got %b want 01", k, busy_tr[1:0]); end
    end
    vectors++;
    if (obs_q.size() != 8) begin miscompares++; $display("FAIL rr_count: got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rr_beat: got %h want %h", o, e); end
    end
  endtask

  task automatic test_fixed_priority();
    beat_t e, o;
    fp = 1'b1;
    do_reset();
    b.s0_araddr = 32'h200; b.s0_arlen = 8'd1; b.s0_arvalid = 1;
    b.s1_araddr = 32'h300; b.s1_arlen = 8'd1; b.s1_arvalid = 1;
    for (int k = 0; k < 3; k++) begin
      do_burst(1'b0, 1, 1'b0, 1'b1);
      vectors++;
      if ({to_flag, obs_grant, obs_araddr} !== {1'b0, 1'b0, 32'h200}) begin
        miscompares++; $display("FAIL fp_grant%0d: got to=%b g=%b addr=%h want 0 0 200", k, to_flag, obs_grant, obs_araddr);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL fp_beat: got %h want %h", o, e); end
    end
    clear_inputs();
    fp = 1'b0;
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    do_reset();
    b.s1_araddr = 32'h500; b.s1_arlen = 8'd7; b.s1_arvalid = 1;
    do_burst(1'b1, 7, 1'b1, 1'b0);
    vectors++;
    if ({to_flag, obs_grant, arready_ok} !== 3'b011 || mirror_bad != 0) begin
      miscompares++; $display("FAIL bp_ctrl: got to=%b g=%b ar=%b mirror_bad=%0d want 0 1 1 0", to_flag, obs_grant, arready_ok, mirror_bad);
    end
    vectors++;
    if (obs_q.size() != 8) begin miscompares++; $display("FAIL bp_count: got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL bp_beat: got %h want %h", o, e); end
    end
    vectors++;
    if (d_err !== 1'b0) begin miscompares++; $display("FAIL bp_err: got %b want 0", d_err); end
  endtask

  task automatic test_rlast_err();
    do_reset();
    b.s0_araddr = 32'h800; b.s0_arlen = 8'd3; b.s0_arvalid = 1;
    do_burst(1'b0, 1, 1'b0, 1'b0);
    vectors++;
    if ({to_flag, busy_tr[1:0], err_tr[1:0]} !== 5'b0_01_10 || obs_q.size() != 2) begin
      miscompares++; $display("FAIL early_rlast: got to=%b busy=%b err=%b n=%0d want 0 01 10 2", to_flag, busy_tr[1:0], err_tr[1:0], obs_q.size());
    end
    do_reset();
    b.s0_araddr = 32'h900; b.s0_arlen = 8'd3; b.s0_arvalid = 1;
    do_burst(1'b0, 4, 1'b0, 1'b0);
    vectors++;
    if ({to_flag, busy_tr[4:0], err_tr[4:0]} !== 11'b0_01111_11000 || obs_q.size() != 5) begin
      miscompares++; $display("FAIL missing_rlast: got to=%b busy=%b err=%b n=%0d want 0 01111 11000 5", to_flag, busy_tr[4:0], err_tr[4:0], obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    beat_t e, o;
    do_reset();
    b.s0_araddr = 32'h400; b.s0_arlen = 8'd7; b.s0_arvalid = 1;
    @(negedge clk);
    b.m_arready = 1;
    @(negedge clk);
    b.m_arready = 0; b.s0_arvalid = 0; b.m_rvalid = 1; b.m_rdata = 32'hDEAD_0000; b.s0_rready = 1;
    @(negedge clk);
    b.m_rdata = 32'hDEAD_0001;
    #1;
    vectors++;
    if ({d_s0_rvalid, d_m_rready, d_busy} !== 3'b111) begin
      miscompares++; $display("FAIL mid_in_data: got %b want 111", {d_s0_rvalid, d_m_rready, d_busy});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({d_m_arvalid, d_m_rready, d_s0_arready, d_s1_arready, d_s0_rvalid, d_s1_rvalid, d_busy, d_grant} !== 8'b0) begin
      miscompares++; $display("FAIL mid_reset_drop: got %b want 00000000",
                              {d_m_arvalid, d_m_rready, d_s0_arready, d_s1_arready, d_s0_rvalid, d_s1_rvalid, d_busy, d_grant});
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    b.s0_araddr = 32'h600; b.s0_arlen = 8'd0; b.s0_arvalid = 1;
    b.s1_araddr = 32'h700; b.s1_arlen = 8'd0; b.s1_arvalid = 1;
    do_burst(1'b0, 0, 1'b0, 1'b0);
    vectors++;
    if ({to_flag, obs_grant, obs_araddr} !== {1'b0, 1'b0, 32'h600} || ar_wait != 0) begin
      miscompares++; $display("FAIL mid_regrant: got to=%b g=%b addr=%h wait=%0d want 0 0 600 0", to_flag, obs_grant, obs_araddr, ar_wait);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mid_beat: got %h want %h", o, e); end
    end
    b.s1_arvalid = 0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_rlast_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns want finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_rd_arbiter2.md
Name: axi_rd_arbiter2

Overview:
- Two-requester AXI4 read-channel (AR+R) arbiter. It shares one downstream read port, such as a crossbar master port or the boot BRAM read port, between two upstream masters, for example the CPU fetch path and a loader/DMA engine.
- Round-robin grant with one outstanding burst at a time. The grant is held from AR handshake until the last R beat.
- A beat counter checks RLAST against ARLEN and flags protocol errors.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR, 1, 1 = round-robin; 0 = fixed priority (s0 wins)

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- s0_araddr / s1_araddr  input  ADDR_W  requester read address
- s0_arlen / s1_arlen  input  8  burst length minus 1
- s0_arsize / s1_arsize  input  3  beat size
- s0_arburst / s1_arburst  input  2  burst type
- s0_arvalid / s1_arvalid  input  1  AR valid
- s0_arready / s1_arready  output  1  AR ready
- s0_rdata / s1_rdata  output  DATA_W  read data
- s0_rresp / s1_rresp  output  2  read response
- s0_rlast / s1_rlast  output  1  last beat
- s0_rvalid / s1_rvalid  output  1  R valid
- s0_rready / s1_rready  input  1  R ready
- m_araddr, m_arlen, m_arsize, m_arburst  output  ADDR_W/8/3/2  downstream AR payload
- m_arvalid  output  1  downstream AR valid
- m_arready  input  1  downstream AR ready
- m_rdata, m_rresp, m_rlast, m_rvalid  input  DATA_W/2/1/1  downstream R channel
- m_rready  output  1  downstream R ready
- grant  output  1  current/last granted requester index
- busy  output  1  high in ADDR or DATA state
- protocol_err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant=0, last_grant=1 (so s0 has first priority), beat_cnt=0, protocol_err=0.
  - All valid/ready outputs are 0. m_ar* payload reads 0.
- IDLE:
  - m_arvalid=0, s*_arready=0, s*_rvalid=0, m_rready=0.
  - If any s*_arvalid=1, register a grant and go to ADDR next cycle. Arbitration latency is 1 cycle.
  - Arbitration with both requesting: RR=1 grants the requester that is not last_grant; RR=0 grants s0.
  - Arbitration with only one requesting: grant that requester.
- ADDR:
  - m_ar* payload and m_arvalid are combinationally muxed from the granted requester.
  - The granted requester's sN_arready equals m_arready; the other requester's arready=0.
  - On m_arvalid&&m_arready: latch len=arlen, clear beat_cnt, go to DATA.
  - If the granted requester drops arvalid before the handshake (protocol violation), stay in ADDR. Do not regrant.
- DATA:
  - The granted sN_r* outputs are driven from m_r*, and m_rready equals the granted sN_rready.
  - The non-granted requester sees rvalid=0, with rdata/rresp/rlast at 0.
  - m_arvalid=0 and both arready=0.
  - Each R handshake increments beat_cnt (8 bits, wraps at 256).
  - On a handshake with m_rlast=1: go to IDLE and set last_grant=grant.
  - If beat_cnt != len on that beat, set protocol_err.
  - If beat_cnt == len and m_rlast=0: set protocol_err and stay in DATA until rlast.
- Back-to-back bursts: the minimum gap is 1 IDLE cycle between the last R beat and the next m_arvalid.
- grant stays stable from entering ADDR until the cycle after the final R beat.
- protocol_err clears only on reset.
- Reset asserted mid-burst: immediately return to IDLE and drop every valid/ready output. Any in-flight downstream burst is abandoned; the system resets the downstream slave together with the arbiter.
- busy = (state != IDLE).
- The design contains no combinational path from m_arready to m_arvalid.

Test Plan:
- Single request: s0 requests araddr=0x100, arlen=3. Required response: m_arvalid rises 1 cycle later with araddr=0x100; 4 R beats reach s0 only; s1_rvalid stays 0; busy drops after the rlast beat.
- Simultaneous requests, RR=1: s0 and s1 assert arvalid on the same cycle from reset. Required response: s0 is served first, then s1; with both held continuously the grants alternate s0,s1,s0,s1.
- RR=0, both requesting continuously: s0 is granted every burst and s1 is starved. Required response: grant remains 0.
- R backpressure: the granted requester toggles rready every cycle during arlen=7. Required response: m_rready mirrors rready; exactly 8 beats are delivered; data order is preserved.
- RLAST error: downstream asserts rlast on beat 2 of arlen=3. Required response: protocol_err=1 and the arbiter returns to IDLE. Separately, with rlast missing on beat 4 the arbiter stays in DATA with protocol_err=1.
- Reset mid-burst: assert reset=0 during beat 1 of an 8-beat burst. Required response: all valid/ready outputs are 0 in the same cycle; after release, the first request is granted normally with s0 priority.
